// File: rtl/zx8x_pkg.sv
// Shared types and default timing for the ZX80/ZX81 cassette pulse player.
package zx8x_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEADER    = 3'd1,
        ST_FETCH     = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_PULSE_HI  = 3'd4,
        ST_PULSE_LO  = 3'd5,
        ST_GAP       = 3'd6,
        ST_DONE      = 3'd7
    } tape_state_t;

    localparam logic [3:0] PULSES_ZERO = 4'd4;
    localparam logic [3:0] PULSES_ONE  = 4'd9;

    localparam int DEF_PULSE_HALF = 975;
    localparam int DEF_BIT_GAP    = 8450;
    localparam int DEF_LEADER     = 3250000;
    localparam logic [7:0] DEF_NAME_CHAR = 8'hA6;

    localparam int LEADER_W    = 22;
    localparam int PULSE_TMR_W = 14;

    function automatic logic [3:0] pulses_for(input logic bit_val);
        return bit_val ? PULSES_ONE : PULSES_ZERO;
    endfunction

endpackage

// File: rtl/zx81_tape_pulse_gen.sv
// Turns one tape bit into its pulse train followed by the inter-bit gap.
// All phase timers advance only on tick; bit_done fires on the last gap tick.
module tape_pulse_gen
    import zx8x_pkg::*;
#(
    parameter int PULSE_HALF = DEF_PULSE_HALF,
    parameter int BIT_GAP    = DEF_BIT_GAP
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic tick,
    input  logic clear,
    input  logic bit_start,
    input  logic bit_val,
    output logic tape_level,
    output logic bit_done
);

    localparam logic [2:0] G_IDLE = 3'd0;
    localparam logic [2:0] G_ARM  = 3'd1;
    localparam logic [2:0] G_HI   = 3'd2;
    localparam logic [2:0] G_LO   = 3'd3;
    localparam logic [2:0] G_GAP  = 3'd4;

    localparam logic [PULSE_TMR_W-1:0] HALF_M1 = PULSE_TMR_W'(PULSE_HALF - 1);
    localparam logic [PULSE_TMR_W-1:0] GAP_M1  = PULSE_TMR_W'(BIT_GAP - 1);

    logic [2:0]             phase_q, phase_d;
    logic [PULSE_TMR_W-1:0] timer_q, timer_d;
    logic [3:0]             pulses_q, pulses_d;

    // Kept out of the always_comb below so the top's bit_start path forms no loop.
    assign bit_done   = tick && (phase_q == G_GAP) && (timer_q == '0);
    assign tape_level = (phase_q == G_HI);

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        phase_d  = phase_q;
        timer_d  = timer_q;
        pulses_d = pulses_q;
        case (phase_q)
            G_ARM: if (tick) phase_d = G_HI;
            G_HI: if (tick) begin
                if (timer_q == '0) begin
                    phase_d = G_LO;
                    timer_d = HALF_M1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            G_LO: if (tick) begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (pulses_q == 4'd1) begin
                    phase_d  = G_GAP;
                    timer_d  = GAP_M1;
                    pulses_d = '0;
                end else begin
                    phase_d  = G_HI;
                    timer_d  = HALF_M1;
                    pulses_d = pulses_q - 1'b1;
                end
            end
            G_GAP: if (tick) begin
                if (timer_q == '0) phase_d = G_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            default: phase_d = G_IDLE;
        endcase

        // A new bit starts high only on a tick, so the first half-period is full length.
        if (bit_start) begin
            pulses_d = pulses_for(bit_val);
            timer_d  = HALF_M1;
            phase_d  = tick ? G_HI : G_ARM;
        end
        if (clear) begin
            phase_d  = G_IDLE;
            timer_d  = '0;
            pulses_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= G_IDLE;
            timer_q  <= '0;
            pulses_q <= '0;
        end else begin
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            pulses_q <= pulses_d;
        end
    end

endmodule

// File: rtl/zx81_tape_player.sv
// Byte/fetch FSM that streams tape RAM bytes through tape_pulse_gen as ZX80/ZX81 audio.
// Define TAPE_PLAYER_PAUSE_EN to add a pause input that freezes playback.
module zx81_tape_player
    import zx8x_pkg::*;
#(
    parameter int         PULSE_HALF = DEF_PULSE_HALF,
    parameter int         BIT_GAP    = DEF_BIT_GAP,
    parameter int         LEADER     = DEF_LEADER,
    parameter logic [7:0] NAME_CHAR  = DEF_NAME_CHAR
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        start,
    input  logic        stop,
`ifdef TAPE_PLAYER_PAUSE_EN
    input  logic        pause,
`endif
    input  logic        zx81,
    input  logic [13:0] length,
    output logic [13:0] rd_addr,
    output logic        rd_req,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);

    localparam logic [LEADER_W-1:0] LEADER_M1 = LEADER_W'(LEADER - 1);

    tape_state_t         state_q, state_d;
    logic [LEADER_W-1:0] timer_q, timer_d;
    logic [13:0]         index_q, index_d;
    logic [13:0]         length_q, length_d;
    logic                name_q, name_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                rd_req_q, rd_req_d;
    logic [13:0]         rd_addr_q, rd_addr_d;
    logic                done_q, done_d;

    logic run, tick, bit_start, bit_val, bit_done, gen_level;

`ifdef TAPE_PLAYER_PAUSE_EN
    logic held_q, held_d;
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif
    assign tick = ce & run;

    tape_pulse_gen #(
        .PULSE_HALF (PULSE_HALF),
        .BIT_GAP    (BIT_GAP)
    ) u_pulse_gen (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .tick       (tick),
        .clear      (stop),
        .bit_start  (bit_start),
        .bit_val    (bit_val),
        .tape_level (gen_level),
        .bit_done   (bit_done)
    );

    // ST_PULSE_HI spans a whole bit; the pulse generator tracks its HI/LO/GAP phases.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        index_d   = index_q;
        length_d  = length_q;
        name_d    = name_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rd_req_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        done_d    = done_q;
        bit_start = 1'b0;
        bit_val   = 1'b0;
`ifdef TAPE_PLAYER_PAUSE_EN
        held_d    = held_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: if (start) begin
                length_d  = length;
                name_d    = zx81;
                index_d   = '0;
                rd_addr_d = '0;
                done_d    = 1'b0;
                if ((length == '0) && !zx81) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LEADER;
                    timer_d = LEADER_M1;
                end
            end
            ST_LEADER: if (tick) begin
                if (timer_q == '0) state_d = ST_FETCH;
                else               timer_d = timer_q - 1'b1;
            end
            ST_FETCH: if (run) begin
                if (name_q) begin
                    name_d    = 1'b0;
                    shift_d   = NAME_CHAR;
                    bit_cnt_d = 3'd7;
                    bit_start = 1'b1;
                    bit_val   = NAME_CHAR[7];
                    state_d   = ST_PULSE_HI;
                end else if (index_q == length_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    rd_addr_d = index_q;
                    rd_req_d  = 1'b1;
                    state_d   = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
`ifdef TAPE_PLAYER_PAUSE_EN
                if (!run) begin
                    if (rd_valid && !held_q) begin
                        shift_d = rd_data;
                        index_d = index_q + 1'b1;
                        held_d  = 1'b1;
                    end
                end else if (held_q) begin
                    held_d    = 1'b0;
                    bit_cnt_d = 3'd7;
                    bit_start = 1'b1;
                    bit_val   = shift_q[7];
                    state_d   = ST_PULSE_HI;
                end else
`endif
                if (rd_valid) begin
                    shift_d   = rd_data;
                    index_d   = index_q + 1'b1;
                    bit_cnt_d = 3'd7;
                    bit_start = 1'b1;
                    bit_val   = rd_data[7];
                    state_d   = ST_PULSE_HI;
                end
            end
            ST_PULSE_HI: if (bit_done) begin
                if (bit_cnt_q == '0) begin
                    state_d = ST_FETCH;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_start = 1'b1;
                    bit_val   = shift_q[6];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop) begin
            state_d  = ST_IDLE;
            rd_req_d = 1'b0;
            done_d   = 1'b0;
`ifdef TAPE_PLAYER_PAUSE_EN
            held_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            index_q   <= '0;
            length_q  <= '0;
            name_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
`ifdef TAPE_PLAYER_PAUSE_EN
            held_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            index_q   <= index_d;
            length_q  <= length_d;
            name_q    <= name_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            done_q    <= done_d;
`ifdef TAPE_PLAYER_PAUSE_EN
            held_q    <= held_d;
`endif
        end
    end

    assign tape_out = gen_level;
    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_zx81_tape_player.sv
// Self-checking bench: decodes the tape waveform back into bytes the way a ROM loader
// would and compares against the bytes the bench put in RAM.
module tb_zx81_tape_player;

    localparam int PH = 2;
    localparam int GP = 5;
    localparam int LD = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        ce = 1'b0, start = 1'b0, stop = 1'b0, zx81 = 1'b0;
    logic [13:0] length = '0;
    logic [7:0]  rd_data = '0;
    logic        rd_valid = 1'b0;
    logic [13:0] rd_addr;
    logic        rd_req, tape_out, busy, done;

    logic [7:0] mem [0:15];
    logic [7:0] exp_q[$];
    int ce_div = 1, ram_lat = 1, ce_cnt = 0;
    int mon_gen = 0, seen_gen = 0;
    int hi_w[$], lo_w[$], rd_q[$];
    int lead_len = 0, run = 0;
    logic lvl = 1'b0, have_hi = 1'b0;
    int n_tests = 0, n_fail = 0;

    zx81_tape_player #(
        .PULSE_HALF (PH),
        .BIT_GAP    (GP),
        .LEADER     (LD)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce       (ce),
        .start    (start),
        .stop     (stop),
        .zx81     (zx81),
        .length   (length),
        .rd_addr  (rd_addr),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .tape_out (tape_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin : ce_drive
        forever begin
            step();
            ce_cnt++;
            ce = ((ce_cnt % ce_div) == 0);
        end
    end

    initial begin : ram_model
        logic [13:0] a;
        forever begin
            step();
            if (rd_req) begin
                a = rd_addr;
                repeat (ram_lat - 1) step();
                rd_data  = mem[a[3:0]];
                rd_valid = 1'b1;
                step();
                rd_valid = 1'b0;
            end
        end
    end

    // Run-length recorder for tape_out plus a log of issued read addresses.
    initial begin : monitor
        forever begin
            @(negedge clk_sys);
            if (mon_gen != seen_gen) begin
                seen_gen = mon_gen;
                hi_w.delete();
                lo_w.delete();
                rd_q.delete();
                run = 0;
                have_hi = 1'b0;
                lvl = 1'b0;
                lead_len = 0;
            end
            if (rd_req) rd_q.push_back(int'(rd_addr));
            if (tape_out != lvl) begin
                if (lvl)          hi_w.push_back(run);
                else if (have_hi) lo_w.push_back(run);
                else              lead_len = run;
                have_hi = have_hi | tape_out;
                lvl = tape_out;
                run = 1;
            end else begin
                run++;
            end
        end
    end

    task automatic analyse(input int div, input int len);
        int bad_hi, bad_lo, bad_grp, cnt, g, nb;
        int groups[$];
        logic [7:0] b;
        bad_hi = 0;
        bad_lo = 0;
        bad_grp = 0;
        foreach (hi_w[i]) if (hi_w[i] != PH * div) bad_hi++;
        cnt = (hi_w.size() > 0) ? 1 : 0;
        foreach (lo_w[i]) begin
            if (lo_w[i] == PH * div) begin
                cnt++;
            end else begin
                groups.push_back(cnt);
                cnt = 1;
                if ((groups.size() % 8) != 0) begin
                    if (lo_w[i] != (PH + GP) * div) bad_lo++;
                end else if (lo_w[i] < (PH + GP) * div) begin
                    bad_lo++;
                end
            end
        end
        if (cnt > 0) groups.push_back(cnt);
        check("hi_width", bad_hi, 0);
        check("lo_width", bad_lo, 0);
        check("bit_count", groups.size(), 8 * exp_q.size());
        nb = groups.size() / 8;
        if (nb > exp_q.size()) nb = exp_q.size();
        for (int j = 0; j < nb; j++) begin
            b = '0;
            for (int k = 0; k < 8; k++) begin
                g = groups[8 * j + k];
                if (g == 9)      b = {b[6:0], 1'b1};
                else if (g == 4) b = {b[6:0], 1'b0};
                else begin
                    b = {b[6:0], 1'b0};
                    bad_grp++;
                end
            end
            check("byte", b, exp_q[j]);
        end
        check("pulse_grp", bad_grp, 0);
        check("leader", int'(lead_len >= LD * div), 1);
        check("rd_count", rd_q.size(), len);
        foreach (rd_q[i]) check("rd_addr", rd_q[i], i);
    endtask

    task automatic play(input int len, input bit zx, input int lat, input int div);
        int n;
        ram_lat = lat;
        ce_div = div;
        exp_q.delete();
        if (zx) exp_q.push_back(8'hA6);
        for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
        step();
        mon_gen++;
        length = 14'(len);
        zx81 = zx;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_start", busy, 1);
        check("done_clr", done, 0);
        n = 0;
        while (!done && n < 8000) begin
            step();
            n++;
        end
        check("done", done, 1);
        check("busy_end", busy, 0);
        analyse(div, len);
    endtask

    initial begin : stimulus
        int n, falls, len, lat, div;
        bit zx;
        logic prev;

        #1 reset_n = 1'b0;
        #1;
        check("rst_tape", tape_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", rd_req, 0);
        check("rst_addr", rd_addr, 0);
        step();
        step();
        reset_n = 1'b1;

        mem[0] = 8'h80;
        play(1, 1'b0, 1, 1);
        mem[0] = 8'h00;
        mem[1] = 8'hFF;
        play(2, 1'b1, 1, 1);
        mem[0] = 8'h80;
        play(1, 1'b0, 1, 4);
        play(1, 1'b0, 10, 1);
        play(0, 1'b1, 1, 1);

        // Stop in the middle of byte 0, after a start that must be ignored while busy.
        mem[0] = 8'h55;
        mem[1] = 8'h3C;
        ram_lat = 1;
        ce_div = 1;
        step();
        mon_gen++;
        length = 14'd2;
        zx81 = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!tape_out && n < 200) begin
            step();
            n++;
        end
        check("stop_hi_seen", tape_out, 1);
        length = 14'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_tape", tape_out, 0);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        check("stop_req", rd_req, 0);
        play(2, 1'b0, 3, 1);

        // Asynchronous reset in the gap after byte 1's first bit.
        mem[0] = 8'h00;
        mem[1] = 8'h80;
        ram_lat = 1;
        ce_div = 1;
        step();
        mon_gen++;
        length = 14'd2;
        zx81 = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        falls = 0;
        prev = 1'b0;
        n = 0;
        while (falls < 41 && n < 4000) begin
            step();
            n++;
            if (prev && !tape_out) falls++;
            prev = tape_out;
        end
        check("falls", falls, 41);
        repeat (3) step();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_addr", rd_addr, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_tape", tape_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_req", rd_req, 0);
        check("arst_addr", rd_addr, 0);
        step();
        reset_n = 1'b1;

        // start and stop together: stop wins, nothing begins.
        step();
        mon_gen++;
        length = 14'd0;
        zx81 = 1'b0;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("ss_done", done, 0);
        check("ss_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        repeat (20) step();
        check("zero_pulses", hi_w.size(), 0);
        check("zero_hold", done, 1);

        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, 3));
            lat = int'($urandom_range(1, 12));
            div = int'($urandom_range(1, 4));
            zx = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
            play(len, zx, lat, div);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
